// File: rtl/noc_pkg.sv
// Shared NoC definitions for the PE-side injector.
// - Flit field offsets. The DST_/SRC_/DATA_ localparams are for the default 2-bit
//   coordinate geometry; the *_lsb() functions give offsets for other geometries.
// - FSM state encoding.
// - Flit assembly helper.
// Flit layout, LSB first: dst y | dst x | src y | src x | payload.
package noc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   function automatic int unsigned dst_x_lsb(input int unsigned ys);
      return ys;
   endfunction

   function automatic int unsigned src_y_lsb(input int unsigned xs, input int unsigned ys);
      return xs + ys;
   endfunction

   function automatic int unsigned src_x_lsb(input int unsigned xs, input int unsigned ys);
      return xs + 2 * ys;
   endfunction

   function automatic int unsigned data_lsb(input int unsigned xs, input int unsigned ys);
      return 2 * xs + 2 * ys;
   endfunction

   localparam int unsigned DEF_X_SIZE = 2;
   localparam int unsigned DEF_Y_SIZE = 2;
   localparam int unsigned DST_Y_LSB  = 0;
   localparam int unsigned DST_X_LSB  = dst_x_lsb(DEF_Y_SIZE);
   localparam int unsigned SRC_Y_LSB  = src_y_lsb(DEF_X_SIZE, DEF_Y_SIZE);
   localparam int unsigned SRC_X_LSB  = src_x_lsb(DEF_X_SIZE, DEF_Y_SIZE);
   localparam int unsigned DATA_LSB   = data_lsb(DEF_X_SIZE, DEF_Y_SIZE);

   // Fields are passed zero-extended to 64 bits; the caller truncates to its flit width.
   function automatic logic [63:0] flit_pack(input int unsigned xs, input int unsigned ys,
                                             input logic [63:0] data, input logic [63:0] sx,
                                             input logic [63:0] sy, input logic [63:0] dx,
                                             input logic [63:0] dy);
      return (data << data_lsb(xs, ys)) | (sx << src_x_lsb(xs, ys)) |
             (sy << src_y_lsb(xs, ys)) | (dx << dst_x_lsb(ys)) | (dy << DST_Y_LSB);
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    write request/data (ignored while full)
//   pop_i, rdata_o     read request (ignored while empty) / head word
//   full_o, empty_o    status decoded from the occupancy register
//   count_o            occupancy, 0..Depth
// Depth must be a power of two so the pointers wrap naturally.
module noc_sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PtrW:0]    count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PtrW + 1)'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + (PtrW + 1)'(1);
         end else if (!do_push && do_pop) begin
            count_q <= count_q - (PtrW + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/noc_pe_injector.sv
// PE-side NoC injector: buffers neuron outputs and replicates each one as a unicast
// flit to every node in a linear destination range [base, base+count), clipped at
// the last mesh node.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   i_valid, i_data, o_ready       neuron result input (o_ready = FIFO not full)
//   cfg_dst_base, cfg_dst_count    destination range, sampled only when a word is loaded
//   i_sw_ready                     switch PE-port ready
//   o_sw_valid, o_sw_data          registered flit to the switch, held under back-pressure
//   o_busy                         FSM sending or FIFO non-empty
//   o_err_overflow                 sticky: a push was attempted while full
module noc_pe_injector
   import noc_pkg::*;
#(
   parameter int unsigned x_coord     = 0,
   parameter int unsigned y_coord     = 0,
   parameter int unsigned X           = 4,
   parameter int unsigned Y           = 4,
   parameter int unsigned data_width  = 8,
   parameter int unsigned x_size      = 2,
   parameter int unsigned y_size      = 2,
   parameter int unsigned total_width = 2 * x_size + 2 * y_size + data_width,
   parameter int unsigned sw_no       = X * Y,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned idx_w       = $clog2(sw_no)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   i_valid,
   input  logic [data_width-1:0]  i_data,
   output logic                   o_ready,
   input  logic [idx_w-1:0]       cfg_dst_base,
   input  logic [idx_w:0]         cfg_dst_count,
   input  logic                   i_sw_ready,
   output logic                   o_sw_valid,
   output logic [total_width-1:0] o_sw_data,
   output logic                   o_busy,
   output logic                   o_err_overflow
);

   localparam int unsigned CntW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

   state_e                 state_q;
   logic [data_width-1:0]  hold_q;
   logic [x_size-1:0]      x_q;
   logic [y_size-1:0]      y_q;
   logic [idx_w:0]         rem_q;
   logic                   valid_q;
   logic [total_width-1:0] flit_q;
   logic                   err_q;

   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [data_width-1:0]  fifo_rdata;
   logic [CntW-1:0]        fifo_count;

   logic [x_size-1:0]      base_x, next_x;
   logic [y_size-1:0]      base_y, next_y;
   logic [idx_w:0]         avail, clip_cnt;
   logic                   accept, last_flit, load;

   function automatic logic [total_width-1:0] mk_flit(input logic [data_width-1:0] d,
                                                      input logic [x_size-1:0]     dx,
                                                      input logic [y_size-1:0]     dy);
      return total_width'(flit_pack(x_size, y_size, 64'(d), 64'(x_coord), 64'(y_coord),
                                    64'(dx), 64'(dy)));
   endfunction

   noc_sync_fifo #(
      .Width (data_width),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rstn),
      .push_i  (fifo_push),
      .wdata_i (i_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      // Split the base index into x/y by comparing against row starts; the last row
      // start not above the base wins. Constant comparators only, no divider.
      base_x = '0;
      base_y = '0;
      for (int unsigned yy = 0; yy < Y; yy++) begin
         if (cfg_dst_base >= idx_w'(yy * X)) begin
            base_y = y_size'(yy);
            base_x = x_size'(cfg_dst_base - idx_w'(yy * X));
         end
      end

      // Destinations remaining before the last node, then clip the requested count.
      avail    = ({1'b0, cfg_dst_base} < (idx_w + 1)'(sw_no)) ?
                 (idx_w + 1)'(sw_no) - {1'b0, cfg_dst_base} : '0;
      clip_cnt = (cfg_dst_count < avail) ? cfg_dst_count : avail;

      if (x_q == x_size'(X - 1)) begin
         next_x = '0;
         next_y = y_q + y_size'(1);
      end else begin
         next_x = x_q + x_size'(1);
         next_y = y_q;
      end
   end

   assign accept    = valid_q & i_sw_ready;
   assign last_flit = (rem_q == (idx_w + 1)'(1));
   // Load a new word when idle, or back-to-back as the last copy of the current one leaves.
   assign load      = ~fifo_empty &
                      ((state_q == ST_IDLE) | ((state_q == ST_SEND) & accept & last_flit));
   assign fifo_pop  = load;
   assign fifo_push = i_valid & ~fifo_full;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         flit_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (i_valid && fifo_full) begin
            err_q <= 1'b1;
         end

         if (load) begin
            hold_q <= fifo_rdata;
            x_q    <= base_x;
            y_q    <= base_y;
            rem_q  <= clip_cnt;
            flit_q <= mk_flit(fifo_rdata, base_x, base_y);
            // An empty (clipped) range discards the word without emitting a flit.
            if (clip_cnt != '0) begin
               state_q <= ST_SEND;
               valid_q <= 1'b1;
            end else begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         end else if (state_q == ST_SEND && accept) begin
            if (last_flit) begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               rem_q   <= '0;
            end else begin
               x_q    <= next_x;
               y_q    <= next_y;
               rem_q  <= rem_q - (idx_w + 1)'(1);
               flit_q <= mk_flit(hold_q, next_x, next_y);
            end
         end
      end
   end

   assign o_sw_valid     = valid_q;
   assign o_sw_data      = flit_q;
   assign o_ready        = (fifo_count != CntW'(FIFO_DEPTH));
   assign o_busy         = (state_q != ST_IDLE) | ~fifo_empty;
   assign o_err_overflow = err_q;

endmodule

// File: tb/tb_noc_pe_injector.sv
// Scoreboard bench for noc_pe_injector with default parameters (4x4 mesh, 8-bit data,
// node (0,0)). Stimulus pushes expected flits into exp_q; the monitor compares every
// presented flit against the queue head and pops it when the switch accepts.
module tb_noc_pe_injector;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        i_valid = 1'b0;
   logic [7:0]  i_data = '0;
   logic        o_ready;
   logic [3:0]  cfg_dst_base = '0;
   logic [4:0]  cfg_dst_count = '0;
   logic        i_sw_ready = 1'b0;
   logic        o_sw_valid;
   logic [15:0] o_sw_data;
   logic        o_busy;
   logic        o_err_overflow;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   noc_pe_injector dut (
      .clk            (clk),
      .rstn           (rstn),
      .i_valid        (i_valid),
      .i_data         (i_data),
      .o_ready        (o_ready),
      .cfg_dst_base   (cfg_dst_base),
      .cfg_dst_count  (cfg_dst_count),
      .i_sw_ready     (i_sw_ready),
      .o_sw_valid     (o_sw_valid),
      .o_sw_data      (o_sw_data),
      .o_busy         (o_busy),
      .o_err_overflow (o_err_overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: runs on the falling edge, mid-cycle between accept edges.
   always @(negedge clk) begin
      if (rstn && o_sw_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_flit: got 0x%0h, expected no flit", o_sw_data);
         end else begin
            chk("flit", 32'(o_sw_data), 32'(exp_q[0]));
            if (i_sw_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      i_valid = 1'b1;
      i_data  = d;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((o_sw_valid || o_busy) && n < 60) begin
         tick();
         n++;
      end
      chk({name, "_idle"}, 32'(o_sw_valid || o_busy), 32'd0);
      chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_valid", 32'(o_sw_valid), 32'd0);
      chk("rst_data", 32'(o_sw_data), 32'h0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_err", 32'(o_err_overflow), 32'd0);
      tick();
      rstn = 1'b1;
      tick();

      // 1: base=1 count=3, continuous ready
      cfg_dst_base  = 4'd1;
      cfg_dst_count = 5'd3;
      i_sw_ready    = 1'b1;
      exp_q.push_back(16'hA504);
      exp_q.push_back(16'hA508);
      exp_q.push_back(16'hA50C);
      push_word(8'hA5);
      chk("t1_lat_before", 32'(o_sw_valid), 32'd0);
      tick();
      chk("t1_lat_valid", 32'(o_sw_valid), 32'd1);
      chk("t1_first", 32'(o_sw_data), 32'hA504);
      tick();
      chk("t1_second", 32'(o_sw_data), 32'hA508);
      tick();
      chk("t1_third", 32'(o_sw_data), 32'hA50C);
      tick();
      chk("t1_end_valid", 32'(o_sw_valid), 32'd0);
      chk("t1_end_busy", 32'(o_busy), 32'd0);
      wait_idle("t1");

      // 2: back-pressure while 0xA508 is presented
      exp_q.push_back(16'hA504);
      exp_q.push_back(16'hA508);
      exp_q.push_back(16'hA50C);
      push_word(8'hA5);
      tick();
      tick();
      chk("t2_present", 32'(o_sw_data), 32'hA508);
      i_sw_ready = 1'b0;
      tick();
      tick();
      chk("t2_hold_valid", 32'(o_sw_valid), 32'd1);
      chk("t2_hold_data", 32'(o_sw_data), 32'hA508);
      i_sw_ready = 1'b1;
      tick();
      chk("t2_next", 32'(o_sw_data), 32'hA50C);
      wait_idle("t2");

      // 3: fill FIFO + hold with switch stalled, then overflow and drain
      i_sw_ready    = 1'b0;
      cfg_dst_base  = 4'd2;
      cfg_dst_count = 5'd1;
      for (int k = 1; k <= 5; k++) exp_q.push_back({8'(k), 8'h08});
      i_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         i_data = 8'(k);
         chk($sformatf("t3_ready_%0d", k), 32'(o_ready), (k <= 5) ? 32'd1 : 32'd0);
         if (k == 6) chk("t3_err_before", 32'(o_err_overflow), 32'd0);
         tick();
      end
      i_valid = 1'b0;
      chk("t3_err_set", 32'(o_err_overflow), 32'd1);
      chk("t3_full", 32'(o_ready), 32'd0);
      i_sw_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t3_b2b_%0d", k), 32'(o_sw_valid), 32'd1);
         tick();
      end
      chk("t3_after_drain", 32'(o_sw_valid), 32'd0);
      wait_idle("t3");
      chk("t3_err_sticky", 32'(o_err_overflow), 32'd1);

      // 4: zero count discards; then base=5 count=1
      cfg_dst_base  = 4'd0;
      cfg_dst_count = 5'd0;
      push_word(8'h11);
      tick();
      chk("t4_discard_valid", 32'(o_sw_valid), 32'd0);
      chk("t4_discard_busy", 32'(o_busy), 32'd0);
      cfg_dst_base  = 4'd5;
      cfg_dst_count = 5'd1;
      exp_q.push_back(16'h2205);
      push_word(8'h22);
      wait_idle("t4");

      // 5: clipped at last node
      cfg_dst_base  = 4'd14;
      cfg_dst_count = 5'd4;
      exp_q.push_back(16'h770B);
      exp_q.push_back(16'h770F);
      push_word(8'h77);
      wait_idle("t5");

      // 6: asynchronous reset while a flit is stalled
      i_sw_ready    = 1'b0;
      cfg_dst_base  = 4'd1;
      cfg_dst_count = 5'd1;
      exp_q.push_back(16'h3304);
      push_word(8'h33);
      push_word(8'h44);
      chk("t6_stalled", 32'(o_sw_valid), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(o_sw_valid), 32'd0);
      chk("t6_rst_data", 32'(o_sw_data), 32'h0);
      chk("t6_rst_ready", 32'(o_ready), 32'd1);
      chk("t6_rst_err", 32'(o_err_overflow), 32'd0);
      chk("t6_rst_busy", 32'(o_busy), 32'd0);
      exp_q.delete();
      tick();
      rstn       = 1'b1;
      i_sw_ready = 1'b1;
      tick();
      exp_q.push_back(16'h5504);
      push_word(8'h55);
      wait_idle("t6");
      chk("t6_err_clear", 32'(o_err_overflow), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000ns");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/noc_pe_injector.md
Name: noc_pe_injector

Overview:
- PE-side network interface that turns neuron output values into NoC flits and injects them into the local switch's PE input port (i_valid_pe / i_data_pe / o_ready_pe on the switch).
- Buffers neuron results in a small FIFO and replicates each result as one unicast flit per destination in a configured linear range of mesh nodes.
- Holds every flit stable under switch back-pressure.

Parameters:
- x_coord, 'd0, X coordinate of the attached switch; becomes the source X field.
- y_coord, 'd0, Y coordinate of the attached switch; becomes the source Y field.
- X, 4, mesh columns.
- Y, 4, mesh rows.
- data_width, 8, payload width.
- x_size, 2, coordinate X field width.
- y_size, 2, coordinate Y field width.
- total_width, 2*x_size+2*y_size+data_width, flit width.
- sw_no, X*Y, node count.
- FIFO_DEPTH, 4, payload FIFO entries (power of 2).
- idx_w, $clog2(sw_no), linear node index width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous active-low.
- i_valid  in  1  neuron output valid (finoutvalid).
- i_data  in  data_width  neuron output value.
- o_ready  out  1  FIFO not full.
- cfg_dst_base  in  idx_w  first destination linear index; index = y*X + x.
- cfg_dst_count  in  idx_w+1  number of destinations, 0..sw_no.
- i_sw_ready  in  1  switch o_ready_pe.
- o_sw_valid  out  1  to switch i_valid_pe.
- o_sw_data  out  total_width  to switch i_data_pe.
- o_busy  out  1  FSM not IDLE or FIFO not empty.
- o_err_overflow  out  1  sticky; push attempted while full.

Behaviour:
- Decided: one clock (clk); reset rstn is asynchronous, active-low.
- Reset clears all state: o_sw_valid=0, o_sw_data=0, o_ready=1, o_busy=0, o_err_overflow=0, FIFO empty, FSM IDLE.
- Flit layout, LSB first:
  - [y_size-1:0] dst y
  - [x_size+y_size-1:y_size] dst x
  - next y_size bits: src y (y_coord)
  - next x_size bits: src x (x_coord)
  - top data_width bits: payload
  - Defaults: bits [1:0]=dst y, [3:2]=dst x, [5:4]=src y, [7:6]=src x, [15:8]=data.
- Push: i_valid & o_ready at edge N writes the FIFO.
- Overflow: i_valid & ~o_ready drops the word and sets o_err_overflow until reset.
- o_ready is ~full, registered from the FIFO count.
- Push and pop in the same cycle are legal in any non-full state.
- FSM has two states:
  - IDLE: if the FIFO is not empty, pop the word into the hold register and latch cur_idx=cfg_dst_base and remaining=min(cfg_dst_count, sw_no-cfg_dst_base), giving clipped destinations.
    - remaining==0: stay IDLE; the word is discarded with no flit.
    - Otherwise go to SEND with o_sw_valid=1.
  - SEND: o_sw_data = {hold, src, x(cur_idx), y(cur_idx)}.
    - Accept = o_sw_valid & i_sw_ready, sampled at the edge.
    - On accept with remaining>1: advance cur_idx, decrement remaining, keep valid.
    - On accept with remaining==1 and FIFO not empty: pop and reload config in the same edge, with no bubble.
    - On accept with remaining==1 and FIFO empty: valid=0, go to IDLE.
    - If i_sw_ready=0: o_sw_data and o_sw_valid are held unchanged.
- Latency: a push at edge N (FIFO empty, IDLE) gives o_sw_valid=1 after edge N+1. One flit per cycle under continuous ready.
- Coordinate counter: x/y are kept as separate counters, with no divider.
  - x increments; at x==X-1, x wraps to 0 and y increments.
  - Initial x/y come from cfg_dst_base by a loaded lookup or iterative split; the load must complete in the IDLE/reload cycle.
- cfg changes take effect only at word load; changes mid-replication are ignored.
- A destination equal to own coordinates is sent normally; the switch loops it back to the PE.
- Capacity: FIFO_DEPTH entries plus 1 hold register.
- Reset mid-SEND: outputs drop asynchronously; the in-flight flit is lost.

Decomposition:
- Shared package noc_pkg holds:
  - flit field offsets/widths (DST_Y_LSB, DST_X_LSB, SRC_Y_LSB, SRC_X_LSB, DATA_LSB)
  - state encoding (ST_IDLE, ST_SEND)
  - function for flit assembly
- One sub-module: noc_sync_fifo. It is parameterised width/depth, uses async active-low reset, and provides full/empty/count.

Test Plan:
- Defaults, cfg base=1 count=3, i_sw_ready=1, push 0xA5 -> flits 0xA504, 0xA508, 0xA50C on 3 consecutive cycles, first valid 1 cycle after push edge, then o_sw_valid=0, o_busy=0.
- Same config, drop i_sw_ready for 2 cycles while 0xA508 is presented -> 0xA508 and valid held 3 cycles, then 0xA50C; no duplicate, no skip.
- i_sw_ready=0, count=1, push 6 consecutive words -> first 5 accepted (4 FIFO + hold), o_ready=0, 6th sets o_err_overflow=1. Releasing ready drains all 5 in order back-to-back.
- count=0, push 0x11; then base=5 count=1, push 0x22 -> no flit for 0x11; single flit 0x2205.
- base=14 count=4, push 0x77 -> exactly 0x770B, 0x770F (clipped at index 15), then idle.
- Assert rstn low while valid&~ready -> o_sw_valid=0 immediately (asynchronous), o_ready=1, o_err_overflow=0, FIFO empty; after release a new push works normally.
